// File: rtl/first_packet_stats_pkg.sv
// Shared types and constants for the packet statistics block.
// Record layout is {len, sum, trunc}; sum is len_width bits wider than the data word.
package first_packet_stats_pkg;

    localparam int WIDTH_DEF     = 8;
    localparam int LEN_WIDTH_DEF = 8;
    localparam int SUM_WIDTH_DEF = WIDTH_DEF + LEN_WIDTH_DEF;

    localparam int         RESULT_DEPTH = 2;
    localparam logic [7:0] SAT8_MAX     = 8'hff;

    typedef struct packed {
        logic [LEN_WIDTH_DEF-1:0] len;
        logic [SUM_WIDTH_DEF-1:0] sum;
        logic                     trunc;
    } stat_rec_t;

    // Adds 0..2 to an 8-bit event counter, pinning at SAT8_MAX.
    function automatic logic [7:0] sat_add8(input logic [7:0] cnt, input logic [1:0] inc);
        logic [8:0] total;
        total = {1'b0, cnt} + {7'b0, inc};
        if (total > {1'b0, SAT8_MAX}) begin
            return SAT8_MAX;
        end
        return total[7:0];
    endfunction

endpackage

// File: rtl/stat_fifo2.sv
// Two-entry in-order FIFO with one pop and up to two pushes per cycle.
// Pop is applied first; push0 wins a single free slot over push1.
module stat_fifo2
    import first_packet_stats_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         pop,
    input  logic         push0,
    input  logic [W-1:0] push0_data,
    input  logic         push1,
    input  logic [W-1:0] push1_data,
    output logic         valid,
    output logic [W-1:0] head,
    output logic         push0_acc,
    output logic         push1_acc
);

    localparam logic [1:0] FULL = 2'(RESULT_DEPTH);

    logic [1:0][W-1:0] mem;
    logic [1:0][W-1:0] mem_nxt;
    logic [1:0]        cnt;
    logic [1:0]        cnt_nxt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem <= '0;
            cnt <= 2'd0;
        end else begin
            mem <= mem_nxt;
            cnt <= cnt_nxt;
        end
    end

    // Vacated slots are zeroed so the head reads as all-zero whenever empty.
    always_comb begin
        mem_nxt   = mem;
        cnt_nxt   = cnt;
        push0_acc = 1'b0;
        push1_acc = 1'b0;

        if (pop && cnt != 2'd0) begin
            mem_nxt[0] = mem[1];
            mem_nxt[1] = '0;
            cnt_nxt    = cnt - 2'd1;
        end

        if (push0 && cnt_nxt != FULL) begin
            push0_acc = 1'b1;
            if (cnt_nxt == 2'd0) begin
                mem_nxt[0] = push0_data;
            end else begin
                mem_nxt[1] = push0_data;
            end
            cnt_nxt = cnt_nxt + 2'd1;
        end

        if (push1 && cnt_nxt != FULL) begin
            push1_acc = 1'b1;
            if (cnt_nxt == 2'd0) begin
                mem_nxt[0] = push1_data;
            end else begin
                mem_nxt[1] = push1_data;
            end
            cnt_nxt = cnt_nxt + 2'd1;
        end
    end

    assign valid = (cnt != 2'd0);
    assign head  = mem[0];

endmodule

// File: rtl/first_packet_stats.sv
// Groups a valid/first word stream into packets and reports length and sum per packet.
// Records go out through a 2-entry buffer; overflowing records and orphan words are counted.
//
// state | meaning
// IDLE  | no packet open; non-first words are orphans
// OPEN  | packet accumulating len/sum
module first_packet_stats
    import first_packet_stats_pkg::*;
#(
    parameter int width     = 8,
    parameter int len_width = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       up_valid,
    input  logic                       up_first,
    input  logic [width-1:0]           up_data,
    input  logic                       flush,
    output logic                       stat_valid,
    input  logic                       stat_ready,
    output logic [len_width-1:0]       stat_len,
    output logic [width+len_width-1:0] stat_sum,
    output logic                       stat_trunc,
    output logic [7:0]                 drop_count,
    output logic [7:0]                 orphan_count
);

    localparam int SUM_W = width + len_width;
    localparam int REC_W = len_width + SUM_W + 1;
    localparam logic [len_width-1:0] LEN_MAX = {len_width{1'b1}};
    localparam logic [len_width-1:0] LEN_ONE = len_width'(1);

    typedef enum logic {
        IDLE = 1'b0,
        OPEN = 1'b1
    } acc_state_t;

    typedef struct packed {
        logic [len_width-1:0] len;
        logic [SUM_W-1:0]     sum;
        logic                 trunc;
    } rec_t;

    acc_state_t           state;
    acc_state_t           state_nxt;
    logic [len_width-1:0] len_q;
    logic [len_width-1:0] len_nxt;
    logic [SUM_W-1:0]     sum_q;
    logic [SUM_W-1:0]     sum_nxt;
    logic                 trunc_q;
    logic                 trunc_nxt;

    logic [SUM_W-1:0] data_ext;
    rec_t             cur_rec;
    rec_t             push0_rec;
    rec_t             push1_rec;
    rec_t             head_rec;
    logic [REC_W-1:0] head_bits;
    logic             push0;
    logic             push1;
    logic             push0_acc;
    logic             push1_acc;
    logic             pop;
    logic             orphan_inc;
    logic [1:0]       drop_inc;

    assign data_ext      = {{len_width{1'b0}}, up_data};
    assign cur_rec.len   = len_q;
    assign cur_rec.sum   = sum_q;
    assign cur_rec.trunc = trunc_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            len_q   <= '0;
            sum_q   <= '0;
            trunc_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            len_q   <= len_nxt;
            sum_q   <= sum_nxt;
            trunc_q <= trunc_nxt;
        end
    end

    // The word is folded in first; flush then closes whatever packet is left open.
    always_comb begin
        state_nxt  = state;
        len_nxt    = len_q;
        sum_nxt    = sum_q;
        trunc_nxt  = trunc_q;
        push0      = 1'b0;
        push1      = 1'b0;
        push0_rec  = cur_rec;
        push1_rec  = cur_rec;
        orphan_inc = 1'b0;

        if (up_valid) begin
            if (up_first) begin
                if (state == OPEN) begin
                    push0 = 1'b1;
                end
                state_nxt = OPEN;
                len_nxt   = LEN_ONE;
                sum_nxt   = data_ext;
                trunc_nxt = 1'b0;
            end else if (state == OPEN) begin
                if (len_q == LEN_MAX) begin
                    trunc_nxt = 1'b1;
                end else begin
                    len_nxt = len_q + LEN_ONE;
                end
                sum_nxt = sum_q + data_ext;
            end else begin
                orphan_inc = 1'b1;
            end
        end

        if (flush && state_nxt == OPEN) begin
            if (push0) begin
                push1           = 1'b1;
                push1_rec.len   = len_nxt;
                push1_rec.sum   = sum_nxt;
                push1_rec.trunc = trunc_nxt;
            end else begin
                push0           = 1'b1;
                push0_rec.len   = len_nxt;
                push0_rec.sum   = sum_nxt;
                push0_rec.trunc = trunc_nxt;
            end
            state_nxt = IDLE;
        end
    end

    assign pop = stat_valid & stat_ready;

    stat_fifo2 #(
        .W (REC_W)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .pop        (pop),
        .push0      (push0),
        .push0_data (push0_rec),
        .push1      (push1),
        .push1_data (push1_rec),
        .valid      (stat_valid),
        .head       (head_bits),
        .push0_acc  (push0_acc),
        .push1_acc  (push1_acc)
    );

    assign head_rec   = head_bits;
    assign stat_len   = head_rec.len;
    assign stat_sum   = head_rec.sum;
    assign stat_trunc = head_rec.trunc;

    assign drop_inc = {1'b0, push0 & ~push0_acc} + {1'b0, push1 & ~push1_acc};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            drop_count   <= 8'd0;
            orphan_count <= 8'd0;
        end else begin
            drop_count   <= sat_add8(drop_count, drop_inc);
            orphan_count <= sat_add8(orphan_count, {1'b0, orphan_inc});
        end
    end

endmodule

// File: tb/tb_first_packet_stats.sv
// Bench for first_packet_stats: directed scenarios plus a randomized run against a queue model.
module tb_first_packet_stats;

    logic        clock;
    logic        reset;
    logic        up_valid;
    logic        up_first;
    logic [7:0]  up_data;
    logic        flush;
    logic        stat_ready;

    logic        stat_valid;
    logic [7:0]  stat_len;
    logic [15:0] stat_sum;
    logic        stat_trunc;
    logic [7:0]  drop_count;
    logic [7:0]  orphan_count;

    logic        stat_valid2;
    logic [1:0]  stat_len2;
    logic [9:0]  stat_sum2;
    logic        stat_trunc2;
    logic [7:0]  drop_count2;
    logic [7:0]  orphan_count2;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state (len_width=8 instance).
    bit m_open;
    int m_len;
    int m_sum;
    bit m_tr;
    int m_drop;
    int m_orphan;
    int q_len[$];
    int q_sum[$];
    bit q_tr[$];

    first_packet_stats #(.width(8), .len_width(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .up_valid     (up_valid),
        .up_first     (up_first),
        .up_data      (up_data),
        .flush        (flush),
        .stat_valid   (stat_valid),
        .stat_ready   (stat_ready),
        .stat_len     (stat_len),
        .stat_sum     (stat_sum),
        .stat_trunc   (stat_trunc),
        .drop_count   (drop_count),
        .orphan_count (orphan_count)
    );

    first_packet_stats #(.width(8), .len_width(2)) dut2 (
        .clock        (clock),
        .reset        (reset),
        .up_valid     (up_valid),
        .up_first     (up_first),
        .up_data      (up_data),
        .flush        (flush),
        .stat_valid   (stat_valid2),
        .stat_ready   (stat_ready),
        .stat_len     (stat_len2),
        .stat_sum     (stat_sum2),
        .stat_trunc   (stat_trunc2),
        .drop_count   (drop_count2),
        .orphan_count (orphan_count2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic model_reset();
        m_open = 0; m_len = 0; m_sum = 0; m_tr = 0;
        m_drop = 0; m_orphan = 0;
        q_len.delete(); q_sum.delete(); q_tr.delete();
    endtask

    task automatic model_push(input int l, input int s, input bit t);
        if (q_len.size() < 2) begin
            q_len.push_back(l); q_sum.push_back(s); q_tr.push_back(t);
        end else if (m_drop < 255) begin
            m_drop++;
        end
    endtask

    // One clock of the behavioural model, using the inputs applied for this edge.
    task automatic model_step();
        if (stat_ready && q_len.size() > 0) begin
            void'(q_len.pop_front()); void'(q_sum.pop_front()); void'(q_tr.pop_front());
        end
        if (up_valid && up_first) begin
            if (m_open) model_push(m_len, m_sum, m_tr);
            m_open = 1; m_len = 1; m_sum = up_data; m_tr = 0;
        end else if (up_valid) begin
            if (!m_open) begin
                if (m_orphan < 255) m_orphan++;
            end else begin
                if (m_len == 255) m_tr = 1; else m_len++;
                m_sum = (m_sum + up_data) % 65536;
            end
        end
        if (flush && m_open) begin
            model_push(m_len, m_sum, m_tr);
            m_open = 0;
        end
    endtask

    task automatic step(input bit v, input bit f, input int d, input bit fl);
        @(negedge clock);
        up_valid = v; up_first = f; up_data = 8'(d); flush = fl;
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        up_valid = 0; up_first = 0; up_data = 0; flush = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        vectors++;
        if (stat_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %0b want 0", stat_valid); end
        vectors++;
        if ({stat_len, stat_sum, stat_trunc} !== 25'd0) begin miscompares++; $display("FAIL reset_rec got %0d/%0d/%0b want 0/0/0", stat_len, stat_sum, stat_trunc); end
        vectors++;
        if (drop_count !== 8'd0 || orphan_count !== 8'd0) begin miscompares++; $display("FAIL reset_counts got %0d/%0d want 0/0", drop_count, orphan_count); end
    endtask

    task automatic test_basic();
        do_reset();
        stat_ready = 1;
        step(1, 1, 3, 0);
        step(1, 0, 4, 0);
        step(1, 0, 5, 0);
        vectors++;
        if (stat_valid !== 1'b0) begin miscompares++; $display("FAIL basic_early got valid %0b want 0", stat_valid); end
        step(1, 1, 10, 0);
        vectors++;
        if (stat_valid !== 1'b1 || stat_len !== 8'd3 || stat_sum !== 16'd12 || stat_trunc !== 1'b0) begin
            miscompares++; $display("FAIL basic_rec1 got v%0b %0d/%0d/%0b want v1 3/12/0", stat_valid, stat_len, stat_sum, stat_trunc);
        end
        step(0, 0, 0, 1);
        vectors++;
        if (stat_valid !== 1'b1 || stat_len !== 8'd1 || stat_sum !== 16'd10) begin
            miscompares++; $display("FAIL basic_rec2 got v%0b %0d/%0d want v1 1/10", stat_valid, stat_len, stat_sum);
        end
        step(0, 0, 0, 0);
        vectors++;
        if (stat_valid !== 1'b0) begin miscompares++; $display("FAIL basic_drain got valid %0b want 0", stat_valid); end
    endtask

    task automatic test_orphan();
        do_reset();
        stat_ready = 1;
        step(1, 0, 7, 0);
        step(1, 0, 8, 0);
        vectors++;
        if (stat_valid !== 1'b0 || orphan_count !== 8'd2) begin
            miscompares++; $display("FAIL orphan_cnt got v%0b orphans %0d want v0 2", stat_valid, orphan_count);
        end
        step(1, 1, 1, 0);
        step(0, 0, 0, 1);
        vectors++;
        if (stat_valid !== 1'b1 || stat_len !== 8'd1 || stat_sum !== 16'd1) begin
            miscompares++; $display("FAIL orphan_rec got v%0b %0d/%0d want v1 1/1", stat_valid, stat_len, stat_sum);
        end
    endtask

    task automatic test_trunc();
        do_reset();
        stat_ready = 1;
        step(1, 1, 1, 0);
        repeat (4) step(1, 0, 1, 0);
        step(0, 0, 0, 1);
        vectors++;
        if (stat_valid2 !== 1'b1 || stat_len2 !== 2'd3 || stat_sum2 !== 10'd5 || stat_trunc2 !== 1'b1) begin
            miscompares++; $display("FAIL trunc_rec got v%0b %0d/%0d/%0b want v1 3/5/1", stat_valid2, stat_len2, stat_sum2, stat_trunc2);
        end
        vectors++;
        if (stat_len !== 8'd5 || stat_trunc !== 1'b0) begin
            miscompares++; $display("FAIL trunc_wide got %0d/%0b want 5/0", stat_len, stat_trunc);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        stat_ready = 0;
        step(1, 1, 1, 1);
        step(1, 1, 2, 1);
        step(1, 1, 3, 1);
        repeat (2) step(0, 0, 0, 0);
        vectors++;
        if (drop_count !== 8'd1 || stat_valid !== 1'b1 || stat_sum !== 16'd1) begin
            miscompares++; $display("FAIL bp_full got drops %0d v%0b sum %0d want 1 v1 1", drop_count, stat_valid, stat_sum);
        end
        stat_ready = 1;
        step(0, 0, 0, 0);
        vectors++;
        if (stat_valid !== 1'b1 || stat_sum !== 16'd2) begin
            miscompares++; $display("FAIL bp_second got v%0b sum %0d want v1 2", stat_valid, stat_sum);
        end
        step(0, 0, 0, 0);
        vectors++;
        if (stat_valid !== 1'b0) begin miscompares++; $display("FAIL bp_empty got valid %0b want 0", stat_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        stat_ready = 1;
        step(1, 1, 4, 0);
        step(1, 0, 5, 0);
        step(1, 1, 6, 1);
        vectors++;
        if (stat_valid !== 1'b1 || stat_len !== 8'd2 || stat_sum !== 16'd9) begin
            miscompares++; $display("FAIL b2b_first got v%0b %0d/%0d want v1 2/9", stat_valid, stat_len, stat_sum);
        end
        step(0, 0, 0, 0);
        vectors++;
        if (stat_valid !== 1'b1 || stat_len !== 8'd1 || stat_sum !== 16'd6) begin
            miscompares++; $display("FAIL b2b_second got v%0b %0d/%0d want v1 1/6", stat_valid, stat_len, stat_sum);
        end
        step(1, 0, 9, 0);
        vectors++;
        if (stat_valid !== 1'b0 || orphan_count !== 8'd1) begin
            miscompares++; $display("FAIL b2b_idle got v%0b orphans %0d want v0 1", stat_valid, orphan_count);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        stat_ready = 0;
        step(1, 1, 5, 1);
        step(1, 1, 2, 0);
        step(1, 0, 3, 0);
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if (stat_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_async got valid %0b want 0", stat_valid); end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        stat_ready = 1;
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        vectors++;
        if (stat_valid !== 1'b0 || drop_count !== 8'd0) begin
            miscompares++; $display("FAIL rstmid_after got v%0b drops %0d want v0 0", stat_valid, drop_count);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 800; i++) begin
            stat_ready = ($urandom_range(0, 2) != 0);
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0),
                 int'($urandom_range(0, 255)), ($urandom_range(0, 9) == 0));
            vectors++;
            if (stat_valid !== (q_len.size() != 0)) begin
                miscompares++; $display("FAIL rand_valid cyc %0d got %0b want %0b", i, stat_valid, q_len.size() != 0);
            end else if (q_len.size() != 0) begin
                vectors++;
                if (stat_len !== 8'(q_len[0]) || stat_sum !== 16'(q_sum[0]) || stat_trunc !== q_tr[0]) begin
                    miscompares++; $display("FAIL rand_rec cyc %0d got %0d/%0d/%0b want %0d/%0d/%0b",
                        i, stat_len, stat_sum, stat_trunc, q_len[0], q_sum[0], q_tr[0]);
                end
            end
            vectors++;
            if (drop_count !== 8'(m_drop) || orphan_count !== 8'(m_orphan)) begin
                miscompares++; $display("FAIL rand_counts cyc %0d got %0d/%0d want %0d/%0d",
                    i, drop_count, orphan_count, m_drop, m_orphan);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        up_valid = 0; up_first = 0; up_data = 0; flush = 0;
        stat_ready = 0;
        model_reset();
        test_reset();
        test_basic();
        test_orphan();
        test_trunc();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/first_packet_stats.md
Name: first_packet_stats

Overview:
- Downstream consumer of a valid/first/data word stream.
- Groups words into packets delimited by the first flag and computes each packet's word count and data sum.
- Emits one result record per packet on a ready/valid output through a 2-entry result buffer.
- The input has no backpressure; result records that cannot be buffered are dropped and counted.

Parameters:
- width, 8, data word width.
- len_width, 8, packet length counter width; sum width is width + len_width.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset; assertion clears all state immediately.
- up_valid  input  1  input word valid.
- up_first  input  1  word is the first word of a packet; qualified by up_valid.
- up_data  input  width  input word.
- flush  input  1  close the currently open packet; single-cycle pulse.
- stat_valid  output  1  result record available (buffer not empty).
- stat_ready  input  1  consumer accepts the record when stat_valid & stat_ready.
- stat_len  output  len_width  word count of the packet.
- stat_sum  output  width+len_width  sum of the packet's words, modulo 2^(width+len_width).
- stat_trunc  output  1  packet length counter saturated.
- drop_count  output  8  saturating count of records dropped because the buffer was full.
- orphan_count  output  8  saturating count of words received while no packet was open.

Behaviour:
- Reset values:
  - stat_valid=0; stat_len, stat_sum and stat_trunc=0.
  - drop_count=0, orphan_count=0.
  - Buffer empty; accumulator state IDLE, len=0, sum=0.
- Accumulator FSM states: IDLE (no packet open) and OPEN.
- IDLE, up_valid & up_first: go OPEN; len=1, sum=up_data, trunc=0.
- IDLE, up_valid & ~up_first: word discarded; orphan_count+1 (saturate at 255).
- OPEN, up_valid & ~up_first:
  - len+1, saturating at 2^len_width-1; trunc=1 once the increment would overflow.
  - sum+=up_data, wrapping modulo.
- OPEN, up_valid & up_first: push the current record {len,sum,trunc}, then restart with len=1, sum=up_data, trunc=0.
- flush: applied after the same-cycle word is processed.
  - The resulting open packet (if any) is pushed; the FSM goes IDLE.
  - flush while IDLE with no word: no effect.
- Same cycle OPEN, up_valid & up_first & flush: two pushes in order — old packet, then the one-word new packet; the FSM ends IDLE.
- Result buffer: 2-entry FIFO, in-order.
  - stat_* outputs come straight from the head entry (registered).
  - Pop on stat_valid & stat_ready.
  - Pop is evaluated before pushes in the same cycle, so a full buffer that pops accepts one push.
  - Each push that finds no free entry is dropped; drop_count+1, saturating at 255.
  - For a double push, the first push takes priority for a free slot.
- Latency: a record closed at edge N is visible on stat_* after edge N (stat_valid high in cycle N+1) if the buffer was empty. Words are never stalled.
- stat_* hold stable while stat_valid & ~stat_ready.
- Reset mid-packet or with a non-empty buffer: the open packet and buffered records are discarded; no record is emitted after reset release.

Decomposition:
- Shared package first_packet_stats_pkg:
  - stat_rec_t struct {len, sum, trunc}, parameterised via localparam widths.
  - Constant RESULT_DEPTH = 2.
  - 8-bit saturating counter max constant.
- One sub-module: stat_fifo2, a 2-entry FIFO with single pop and up to two pushes per cycle, reporting per-push accept.
- Accumulator FSM and the counters stay in the top module.

Test Plan:
- Words first=1:3, 4, 5, then first=1:10, with stat_ready=1 → record {len=3, sum=12, trunc=0} valid the cycle after the word 10 arrives; then flush → {len=1, sum=10}.
- After reset, words 7, 8 without first → no record; orphan_count=2; a later first=1:1 followed by flush → {len=1, sum=1}.
- len_width=2; packet of 5 words each 1, then flush → {len=3, sum=5, trunc=1}.
- stat_ready=0; close 3 one-word packets (data 1, 2, 3) → records 1 and 2 buffered, drop_count=1; raise stat_ready → records with sum 1 then 2, then stat_valid=0.
- OPEN packet {2 words, sum 9}; in one cycle up_valid & up_first(data 6) & flush with buffer empty → two records in order: {2, 9}, then {1, 6}; FSM IDLE.
- Assert reset mid-packet with 1 buffered record and stat_ready=0 → stat_valid drops asynchronously; after release, a flush produces no record.
